// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and types for the convolution window feeder.
package conv_window_feeder_pkg;

    // Address/dimension width, element width and SRAM beat width.
    localparam int CWF_ADDR_WIDTH   = 13;
    localparam int CWF_DATA_WIDTH   = 8;
    localparam int CWF_SRAM_WIDTH_O = 64;

    // Lanes per beat and its log2, shared with the convolution engine.
    localparam int CWF_LANES        = CWF_SRAM_WIDTH_O / CWF_DATA_WIDTH;
    localparam int CWF_LANE_LOG2    = $clog2(CWF_LANES);

    // Feeder control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_GAP   = 2'd2,
        ST_FIN   = 2'd3
    } cwf_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Window address generator: kernel-row / chunk / output-column / output-row
// counter nest plus the SRAM element address adder.
module window_addr_gen
    import conv_window_feeder_pkg::*;
#(
    parameter int ADDR_WIDTH = CWF_ADDR_WIDTH,
    parameter int LANE_LOG2  = CWF_LANE_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_advance,
    input  logic [ADDR_WIDTH-1:0] i_img_row,
    input  logic [ADDR_WIDTH-1:0] i_img_col,
    input  logic [ADDR_WIDTH-1:0] i_ker_row,
    input  logic [ADDR_WIDTH-1:0] i_ker_col,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_out_r,
    output logic [ADDR_WIDTH-1:0] o_out_c,
    output logic [ADDR_WIDTH-1:0] o_chunk_rem,
    output logic                  o_last_beat,
    output logic                  o_last_window
);

    // Column offset added per chunk (one beat worth of lanes).
    localparam logic [ADDR_WIDTH:0]   LANE_STEP = (ADDR_WIDTH+1)'(1 << LANE_LOG2);
    localparam logic [ADDR_WIDTH-1:0] LANE_INC  = ADDR_WIDTH'(1 << LANE_LOG2);

    logic [ADDR_WIDTH-1:0] r_img_row;
    logic [ADDR_WIDTH-1:0] r_img_col;
    logic [ADDR_WIDTH-1:0] r_ker_row;
    logic [ADDR_WIDTH-1:0] r_ker_col;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_col_off;
    logic [ADDR_WIDTH-1:0] r_out_r;
    logic [ADDR_WIDTH-1:0] r_out_c;

    logic                  w_last_chunk;
    logic                  w_last_row;
    logic                  w_last_col;
    logic [ADDR_WIDTH-1:0] w_row_idx;

    // The chunk is the last of its kernel row once the next chunk would start
    // at or past ker_col; the extra bit keeps the compare free of wrap.
    assign w_last_chunk  = ({1'b0, r_col_off} + LANE_STEP) >= {1'b0, r_ker_col};
    assign w_last_row    = (r_row == r_ker_row - ADDR_WIDTH'(1));
    assign w_last_col    = (r_out_c == r_img_col - r_ker_col);
    assign o_last_beat   = w_last_chunk && w_last_row;
    assign o_last_window = w_last_col && (r_out_r == r_img_row - r_ker_row);

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    assign w_row_idx   = r_out_r + r_row;
    assign o_addr      = r_base + w_row_idx * r_img_col + r_out_c + r_col_off;
    assign o_out_r     = r_out_r;
    assign o_out_c     = r_out_c;
    assign o_chunk_rem = r_ker_col - r_col_off;

    // Capture job geometry on load; step beats during fetch, windows during gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_img_row <= '0;
            r_img_col <= '0;
            r_ker_row <= '0;
            r_ker_col <= '0;
            r_base    <= '0;
            r_row     <= '0;
            r_col_off <= '0;
            r_out_r   <= '0;
            r_out_c   <= '0;
        end else if (i_load) begin
            r_img_row <= i_img_row;
            r_img_col <= i_img_col;
            r_ker_row <= i_ker_row;
            r_ker_col <= i_ker_col;
            r_base    <= i_base_addr;
            r_row     <= '0;
            r_col_off <= '0;
            r_out_r   <= '0;
            r_out_c   <= '0;
        end else begin
            if (i_step) begin
                if (w_last_chunk) begin
                    r_col_off <= '0;
                    r_row     <= w_last_row ? '0 : r_row + ADDR_WIDTH'(1);
                end else begin
                    r_col_off <= r_col_off + LANE_INC;
                end
            end
            if (i_advance) begin
                if (w_last_col) begin
                    r_out_c <= '0;
                    r_out_r <= r_out_r + ADDR_WIDTH'(1);
                end else begin
                    r_out_c <= r_out_c + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Convolution window feeder: walks every valid-convolution window, reads the
// image SRAM one beat per cycle and hands masked beats to the engine.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int ADDR_WIDTH   = CWF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CWF_DATA_WIDTH,
    parameter int SRAM_WIDTH_O = CWF_SRAM_WIDTH_O
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_img_row,
    input  logic [ADDR_WIDTH-1:0]   i_img_col,
    input  logic [ADDR_WIDTH-1:0]   i_ker_row,
    input  logic [ADDR_WIDTH-1:0]   i_ker_col,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    output logic                    o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_sram_rd_addr,
    input  logic [SRAM_WIDTH_O-1:0] i_sram_rd_data,
    output logic                    o_conv_en,
    output logic [SRAM_WIDTH_O-1:0] o_conv_data,
    output logic [ADDR_WIDTH-1:0]   o_out_r,
    output logic [ADDR_WIDTH-1:0]   o_out_c,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int LANES     = SRAM_WIDTH_O / DATA_WIDTH;
    localparam int LANE_LOG2 = $clog2(LANES);

    cwf_state_t            r_state;
    cwf_state_t            w_state_next;
    logic                  w_load;
    logic                  w_step;
    logic                  w_advance;
    logic                  w_rd_en;
    logic                  w_degenerate;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_out_r;
    logic [ADDR_WIDTH-1:0] w_out_c;
    logic [ADDR_WIDTH-1:0] w_chunk_rem;
    logic                  w_last_beat;
    logic                  w_last_window;
    logic [LANES-1:0]      w_lane_live;

    logic                  r_conv_en;
    logic [ADDR_WIDTH-1:0] r_out_r;
    logic [ADDR_WIDTH-1:0] r_out_c;
    logic [LANES-1:0]      r_lane_live;
    logic                  r_done;

    window_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_LOG2  (LANE_LOG2)
    ) u_addr_gen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_advance     (w_advance),
        .i_img_row     (i_img_row),
        .i_img_col     (i_img_col),
        .i_ker_row     (i_ker_row),
        .i_ker_col     (i_ker_col),
        .i_base_addr   (i_base_addr),
        .o_addr        (w_addr),
        .o_out_r       (w_out_r),
        .o_out_c       (w_out_c),
        .o_chunk_rem   (w_chunk_rem),
        .o_last_beat   (w_last_beat),
        .o_last_window (w_last_window)
    );

    // Jobs with an empty output plane skip straight to completion.
    assign w_degenerate = (i_img_row == '0) || (i_img_col == '0) ||
                          (i_ker_row == '0) || (i_ker_col == '0) ||
                          (i_ker_row > i_img_row) || (i_ker_col > i_img_col);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_advance    = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = w_degenerate ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                w_step  = 1'b1;
                if (w_last_beat) begin
                    w_state_next = w_last_window ? ST_FIN : ST_GAP;
                end
            end
            ST_GAP: begin
                w_advance    = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A lane is live while its column index is still inside the kernel row.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_live[gi] = (w_chunk_rem > ADDR_WIDTH'(gi));
            assign o_conv_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (r_conv_en && r_lane_live[gi]) ? i_sram_rd_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                               : {DATA_WIDTH{1'b0}};
        end
    endgenerate

    // Delay the read strobe, its window position and lane mask by one cycle
    // so they line up with the data returned by the SRAM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_conv_en   <= 1'b0;
            r_out_r     <= '0;
            r_out_c     <= '0;
            r_lane_live <= '0;
        end else begin
            r_conv_en <= w_rd_en;
            if (w_rd_en) begin
                r_out_r     <= w_out_r;
                r_out_c     <= w_out_c;
                r_lane_live <= w_lane_live;
            end
        end
    end

    // Completion pulse follows the single FIN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
        end
    end

    assign o_sram_rd_en   = w_rd_en;
    assign o_sram_rd_addr = w_rd_en ? w_addr : '0;
    assign o_conv_en      = r_conv_en;
    assign o_out_r        = r_out_r;
    assign o_out_c        = r_out_c;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a reference model expands each job
// into expected reads/beats/done, a monitor compares against the DUT.
module tb_conv_window_feeder;

    localparam int AW = 13;
    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] img_row, img_col, ker_row, ker_col, base_addr;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic [63:0] rd_data;
    logic        conv_en;
    logic [63:0] conv_data;
    logic [12:0] out_r, out_c;
    logic        busy, done;

    always #5 clk = ~clk;

    conv_window_feeder dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_img_row      (img_row),
        .i_img_col      (img_col),
        .i_ker_row      (ker_row),
        .i_ker_col      (ker_col),
        .i_base_addr    (base_addr),
        .o_sram_rd_en   (rd_en),
        .o_sram_rd_addr (rd_addr),
        .i_sram_rd_data (rd_data),
        .o_conv_en      (conv_en),
        .o_conv_data    (conv_data),
        .o_out_r        (out_r),
        .o_out_c        (out_c),
        .o_busy         (busy),
        .o_done         (done)
    );

    // Image memory and a one-cycle-latency read port; garbage when not read.
    logic [7:0] mem [8192];
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < NL; i++) begin
                rd_data[i*8 +: 8] <= mem[13'(rd_addr + 13'(i))];
            end
        end else begin
            rd_data <= {$urandom, $urandom};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [63:0] data;
        int          orow;
        int          ocol;
    } beat_t;

    beat_t rd_q[$];
    beat_t cv_q[$];
    int    done_q[$];

    int checks = 0;
    int errors = 0;
    int timeout_cnt = 0;
    int timeout_seen = 0;
    int job_t = 0;
    int job_len = 0;
    bit job_valid = 1'b0;

    // Reference model: expand a job into its reads, beats and completion cycle.
    task automatic push_job(input int ir, input int ic, input int kr, input int kc,
                            input int base, input int c, output int len);
        int    orr, occ, ch, rel;
        beat_t e;
        if (ir == 0 || ic == 0 || kr == 0 || kc == 0 || kr > ir || kc > ic) begin
            len = 2;
        end else begin
            orr = ir - kr + 1;
            occ = ic - kc + 1;
            ch  = (kc + NL - 1) / NL;
            rel = 1;
            for (int wr = 0; wr < orr; wr++) begin
                for (int wc = 0; wc < occ; wc++) begin
                    for (int r = 0; r < kr; r++) begin
                        for (int k = 0; k < ch; k++) begin
                            e.addr = 13'(base + (wr + r) * ic + wc + k * NL);
                            for (int i = 0; i < NL; i++) begin
                                logic [12:0] a;
                                a = e.addr + 13'(i);
                                e.data[i*8 +: 8] = (k * NL + i < kc) ? mem[a] : 8'h00;
                            end
                            e.orow = wr;
                            e.ocol = wc;
                            e.cyc  = c + rel;
                            rd_q.push_back(e);
                            e.cyc  = c + rel + 1;
                            cv_q.push_back(e);
                            rel++;
                        end
                    end
                    rel++;  // idle cycle between windows
                end
            end
            len = rel;
        end
        done_q.push_back(c + len);
    endtask

    // mode 0: plain job; 1: re-pulse start mid-job; 2: reset during window 2.
    task automatic run_job(input int ir, input int ic, input int kr, input int kc,
                           input int base, input int mode);
        int c, len;
        @(negedge clk);
        c = cyc;
        push_job(ir, ic, kr, kc, base, c, len);
        img_row   = 13'(ir);
        img_col   = 13'(ic);
        ker_row   = 13'(kr);
        ker_col   = 13'(kc);
        base_addr = 13'(base);
        start     = 1'b1;
        job_t     = c;
        job_len   = len;
        job_valid = 1'b1;
        $display("job img=%0dx%0d ker=%0dx%0d base=%0d mode=%0d expected_len=%0d",
                 ir, ic, kr, kc, base, mode, len);
        @(negedge clk);
        start     = 1'b0;
        img_row   = 13'($urandom_range(0, 8191));
        img_col   = 13'($urandom_range(0, 8191));
        ker_row   = 13'($urandom_range(0, 8191));
        ker_col   = 13'($urandom_range(0, 8191));
        base_addr = 13'($urandom_range(0, 8191));
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (mode == 2) begin
            while (cyc < c + 6) @(negedge clk);
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            job_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            for (int n = 0; n < len + 20 && done_q.size() != 0; n++) @(negedge clk);
            if (done_q.size() != 0) timeout_cnt++;
            repeat (3) @(negedge clk);
        end
    endtask

    // Monitor: compare every read, beat, done and busy against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        logic  exp_busy;
        if (timeout_cnt != timeout_seen) begin
            timeout_seen = timeout_cnt;
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, required done within job bound (cycle %0d)", cyc);
        end
        if (!rst_n) begin
            checks++;
            if ({rd_en, rd_addr, conv_en, conv_data, out_r, out_c, busy, done} != '0) begin
                errors++;
                $display("FAIL reset_outputs: got rd_en=%b addr=%0d conv_en=%b data=%h r=%0d c=%0d busy=%b done=%b, required all 0",
                         rd_en, rd_addr, conv_en, conv_data, out_r, out_c, busy, done);
            end
            rd_q.delete();
            cv_q.delete();
            done_q.delete();
        end else begin
            if (job_valid) begin
                exp_busy = (cyc - job_t >= 1) && (cyc - job_t < job_len);
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy: got %b, required %b at rel cycle %0d", busy, exp_busy, cyc - job_t);
                end
            end
            if (rd_en) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_read: got unexpected read addr %0d at cycle %0d, required none", rd_addr, cyc);
                end else begin
                    e = rd_q.pop_front();
                    if (rd_addr !== e.addr || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sram_read: got addr %0d at cycle %0d, required addr %0d at cycle %0d",
                                 rd_addr, cyc, e.addr, e.cyc);
                    end
                end
            end
            if (conv_en) begin
                checks++;
                if (cv_q.size() == 0) begin
                    errors++;
                    $display("FAIL conv_beat: got unexpected beat %h at cycle %0d, required none", conv_data, cyc);
                end else begin
                    e = cv_q.pop_front();
                    if (conv_data !== e.data || cyc != e.cyc ||
                        int'(out_r) != e.orow || int'(out_c) != e.ocol) begin
                        errors++;
                        $display("FAIL conv_beat: got data %h pos (%0d,%0d) cycle %0d, required data %h pos (%0d,%0d) cycle %0d",
                                 conv_data, out_r, out_c, cyc, e.data, e.orow, e.ocol, e.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: got unexpected done at cycle %0d, required none", cyc);
                end else begin
                    int exp_c;
                    exp_c = done_q.pop_front();
                    if (cyc != exp_c || rd_q.size() != 0 || cv_q.size() != 0) begin
                        errors++;
                        $display("FAIL done: got done at cycle %0d with %0d reads/%0d beats pending, required cycle %0d with none pending",
                                 cyc, rd_q.size(), cv_q.size(), exp_c);
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no end of stimulus, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        rst_n     = 1'b0;
        start     = 1'b0;
        img_row   = '0;
        img_col   = '0;
        ker_row   = '0;
        ker_col   = '0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_job(4, 4, 3, 3, 0, 0);         // basic 4x4 / 3x3
        run_job(4, 12, 2, 10, 37, 0);      // two chunks per kernel row
        run_job(4, 4, 5, 3, 0, 0);         // kernel taller than image
        run_job(4, 4, 3, 3, 100, 1);       // start re-pulsed mid-job
        run_job(4, 4, 3, 3, 0, 2);         // reset during window 2
        run_job(4, 4, 3, 3, 0, 0);         // identical job after reset
        run_job(4, 4, 3, 3, 8190, 0);      // address wrap
        run_job(0, 5, 1, 1, 0, 0);         // zero dimension
        run_job(3, 3, 2, 4, 0, 0);         // kernel wider than image
        run_job(1, 8, 1, 8, 500, 0);       // single full-width window
        for (int j = 0; j < 6; j++) begin
            int ir, ic, kr, kc;
            ir = int'($urandom_range(1, 6));
            ic = int'($urandom_range(1, 20));
            kr = int'($urandom_range(1, ir));
            kc = int'($urandom_range(1, ic));
            run_job(ir, ic, kr, kc, int'($urandom_range(0, 8191)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streams kernel-window image data into the `convolution` engine. For every output position of a valid (no-padding, stride-1) convolution, it reads the image SRAM row by row. It presents packed `SRAM_WIDTH_O`-wide beats on the engine's `data_in`, together with the engine's `en` strobe, in the exact order the engine's row/column chunk counters consume them. It sits between the image SRAM read port and the `convolution` data input, and is the producer end of that interface.

## Interface
- `ADDR_WIDTH`, 13, width of every dimension, index and SRAM address.
- `DATA_WIDTH`, 8, bits per image element.
- `SRAM_WIDTH_O`, from `params.vh` (64), beat width. Lane count `N = SRAM_WIDTH_O/DATA_WIDTH`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that launches a job. Ignored unless the block is idle.
- `img_row`, `img_col`, `ker_row`, `ker_col` in ADDR_WIDTH: job dimensions, captured on an accepted `start`.
- `base_addr` in ADDR_WIDTH: element address of image element (0,0), captured on `start`.
- `sram_rd_en` out 1: image SRAM read strobe.
- `sram_rd_addr` out ADDR_WIDTH: element address. The SRAM returns N consecutive elements from this address.
- `sram_rd_data` in SRAM_WIDTH_O: read data, valid exactly 1 cycle after `sram_rd_en`. Lane i (bits `i*DATA_WIDTH +: DATA_WIDTH`) holds element addr+i.
- `conv_en` out 1: drives the engine `en`. High during the beats of one window.
- `conv_data` out SRAM_WIDTH_O: drives the engine `data_in`, valid while `conv_en` is high.
- `out_r`, `out_c` out ADDR_WIDTH: output position of the window currently on `conv_data`.
- `busy` out 1: high from an accepted `start` through `done`.
- `done` out 1: one-cycle pulse after the last beat of the last window.

## Operation
- Geometry:
  - `OR = img_row-ker_row+1`, `OC = img_col-ker_col+1`.
  - Chunks per kernel row `CH = ceil(ker_col/N)`.
  - Beats per window `B = ker_row*CH`.
- Window order: raster, `out_c` fastest, then `out_r`.
- Beat order within a window: kernel row `r` = 0..ker_row-1, and within each row chunk `k` = 0..CH-1.
- Read address for a beat: `base_addr + (out_r+r)*img_col + out_c + k*N`. Arithmetic is modulo 2^ADDR_WIDTH, with no overflow detection.
- Lane masking: lane i of chunk k is forced to 0 when `k*N+i >= ker_col`. Unused lanes are never stale data.
- FSM states:
  - IDLE: `start` moves to FETCH. If any dimension is 0, or `ker_row>img_row`, or `ker_col>img_col`, go directly to FIN instead.
  - FETCH: one read per cycle, B consecutive cycles. After the last beat, go to GAP, or to FIN if this was the last window.
  - GAP: exactly one cycle, no read. Advance `out_c`/`out_r`, then return to FETCH. The gap gives the engine one low `en` cycle so its chunk counters restart at 0.
  - FIN: wait until the final read's data has been presented, pulse `done`, return to IDLE.
- `start` while busy has no effect. Dimensions are stable internally for the whole job.
- No backpressure: the engine accepts one beat per cycle while `en` is high.

## Timing
- Reset values: `sram_rd_en=0`, `sram_rd_addr=0`, `conv_en=0`, `conv_data=0`, `out_r=out_c=0`, `busy=0`, `done=0`, FSM=IDLE.
- Reset asserted mid-job aborts immediately. No `done` is issued, and any in-flight read data is discarded.
- `start` at cycle t:
  - `busy` and the first `sram_rd_en` at t+1.
  - First `conv_en` and `conv_data` at t+2.
- `conv_en`, `conv_data`, `out_r` and `out_c` are registered copies of `sram_rd_en` and its coordinates, delayed 1 cycle and aligned with `sram_rd_data`.
- Each window holds `conv_en` high for B cycles, followed by exactly 1 low cycle.
- Total job length from `start` to `done`: `OR*OC*(B+1)+1` cycles. `done` comes 1 cycle after the last `conv_en`; `busy` falls with `done`.
- Degenerate job: `done` at t+2 with no reads.

## Structure
- `params.vh` holds `SRAM_WIDTH_O`. The lane count N and its log2 are derived constants there, shared with `convolution`.
- One sub-module, `window_addr_gen`: the r/k/out_c/out_r counter nest plus the address adder. It exposes `last_beat` and `last_window` flags.
- The parent holds the FSM, the 1-cycle read-data alignment register and the lane mask.

## Test plan
- 4x4 image, 3x3 kernel, `base_addr=0`, N=8:
  - 4 windows of 3 beats.
  - Window (0,0) addresses 0,4,8; window (1,1) addresses 5,9,13.
  - Lanes 3..7 of every beat are 0.
  - `done` at start+17.
- `ker_col=10`, N=8:
  - CH=2, chunk 0 has all lanes live; chunk 1 has lanes 2..7 zero.
  - Chunk 1 address = chunk 0 address + 8.
- `ker_row=5` with `img_row=4`: no `sram_rd_en`; `done` 2 cycles after `start`; `busy` high only at start+1.
- `start` re-pulsed mid-job, plus `base_addr` changed: no effect on addresses; a single `done`.
- Reset asserted during FETCH of window 2: all outputs 0 in the same cycle. A new `start` after release reproduces the first test exactly.
- `base_addr=8190`, `ADDR_WIDTH=13`: addresses wrap modulo 8192, e.g. element (0,3) reads address 1.
